neuron_weight_bank: RTL and testbench

- Parametrised successor to the single-neuron weight RAM, sized for one full layer.
- Holds DEPTH weights plus one bias word for each of N_NEURONS neurons.
- Loaded once per inference configuration from a serial weight stream using a valid/ready handshake.
- Read in broadcast mode: one address returns the word at that index for every neuron in parallel, feeding the layer's MAC array.

---
 rtl/nwb_pkg.sv | 17 +
 rtl/nwb_ram.sv | 34 +++
 rtl/neuron_weight_bank.sv | 134 +++++++++++++
 tb/tb_neuron_weight_bank.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nwb_pkg.sv
// nwb_pkg: shared definitions for the neuron weight bank.
//   nwb_state_t    - load/read controller states.
//   nwb_word_count - number of words in one complete layer load stream
//                    (DEPTH weights plus one bias for every neuron).
package nwb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } nwb_state_t;

  function automatic int nwb_word_count(input int n_neurons, input int depth);
    return n_neurons * (depth + 1);
  endfunction

endpackage

// File: rtl/nwb_ram.sv
// nwb_ram: single-port weight store for one neuron, WORDS entries of WIDTH
// bits, with a registered synchronous read so it maps onto one block RAM.
// Ports:
//   clock - rising-edge clock
//   we    - write wdata to mem[addr]
//   re    - load rdata from mem[addr]; rdata holds when re is low
//   addr  - shared read/write word index
//   wdata - write data
//   rdata - registered read data (no reset, block-RAM output register)
module nwb_ram #(
  parameter int WIDTH = 16,
  parameter int WORDS = 170,
  parameter int AW    = 8
) (
  input  logic             clock,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/neuron_weight_bank.sv
// neuron_weight_bank: weight and bias storage for one layer of N_NEURONS
// neurons. A serial valid/ready stream fills neuron 0 (DEPTH weights, then
// its bias at index DEPTH), then neuron 1, and so on. Once the whole layer is
// loaded, a broadcast read returns word rd_addr of every neuron at once.
// Ports:
//   clock, resetn      - clock, asynchronous active-low reset
//   load_start         - pulse that (re)starts a load from neuron 0, word 0
//   w_data/w_valid     - incoming weight/bias word and its valid
//   w_ready            - high while a load is in progress
//   rd_en/rd_addr      - read request and word index (0..DEPTH)
//   rd_data            - neuron n at [n*WIDTH +: WIDTH], one cycle after rd_en
//   rd_valid           - rd_data belongs to a read issued last cycle
//   rd_addr_err        - that read was beyond DEPTH (rd_data forced to 0)
//   neuron_loaded      - per-neuron complete flags for the current load
//   all_loaded         - every neuron loaded, reads are honoured
module neuron_weight_bank
  import nwb_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int DEPTH     = 169,
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 10
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       load_start,
  input  logic [WIDTH-1:0]           w_data,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic                       rd_en,
  input  logic [ADDR_BITS-1:0]       rd_addr,
  output logic [N_NEURONS*WIDTH-1:0] rd_data,
  output logic                       rd_valid,
  output logic                       rd_addr_err,
  output logic [N_NEURONS-1:0]       neuron_loaded,
  output logic                       all_loaded
);

  localparam int KW = $clog2(DEPTH + 1);
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  nwb_state_t     state;
  logic [KW-1:0]  k;
  logic [NW-1:0]  n;
  logic           accept;
  logic           word_done;
  logic           last_word;
  logic           rd_fire;
  logic           rd_oor;
  logic           out_zero;
  logic [KW-1:0]  ram_addr;
  logic [WIDTH-1:0] ram_q [N_NEURONS];

  // A load_start in the same cycle as w_valid wins: the word is dropped.
  assign accept    = w_ready && w_valid && !load_start;
  assign word_done = (k == KW'(DEPTH));
  assign last_word = word_done && (n == NW'(N_NEURONS - 1));
  assign rd_oor    = (rd_addr > ADDR_BITS'(DEPTH));
  assign rd_fire   = rd_en && (state == READY);

  // The RAMs are single-port: the load counter owns the address while
  // loading, the read port owns it otherwise. Range-checked reads never use
  // the truncated address.
  assign ram_addr = (state == LOAD) ? k : rd_addr[KW-1:0];

  // Load controller. load_start restarts from any state, so it is checked
  // ahead of the per-state handshake. w_ready is registered alongside the
  // state and is high exactly while in LOAD.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      w_ready       <= 1'b0;
      k             <= '0;
      n             <= '0;
      neuron_loaded <= '0;
      all_loaded    <= 1'b0;
    end else if (load_start) begin
      state         <= LOAD;
      w_ready       <= 1'b1;
      k             <= '0;
      n             <= '0;
      neuron_loaded <= '0;
      all_loaded    <= 1'b0;
    end else if (accept) begin
      if (word_done) begin
        neuron_loaded <= neuron_loaded | (N_NEURONS'(1) << n);
        k             <= '0;
        n             <= n + NW'(1);
        if (last_word) begin
          state      <= READY;
          w_ready    <= 1'b0;
          all_loaded <= 1'b1;
        end
      end else begin
        k <= k + KW'(1);
      end
    end
  end

  // Read pipeline. out_zero masks the RAM outputs after reset and after an
  // out-of-range read; it only changes on an honoured read, so rd_data holds
  // its value between reads exactly like the RAM output registers do.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_valid    <= 1'b0;
      rd_addr_err <= 1'b0;
      out_zero    <= 1'b1;
    end else begin
      rd_valid    <= rd_fire;
      rd_addr_err <= rd_fire && rd_oor;
      if (rd_fire) begin
        out_zero <= rd_oor;
      end
    end
  end

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_bank
    nwb_ram #(
      .WIDTH (WIDTH),
      .WORDS (DEPTH + 1),
      .AW    (KW)
    ) u_ram (
      .clock (clock),
      .we    (accept && (n == NW'(i))),
      .re    (rd_fire && !rd_oor),
      .addr  (ram_addr),
      .wdata (w_data),
      .rdata (ram_q[i])
    );

    assign rd_data[i*WIDTH +: WIDTH] = out_zero ? '0 : ram_q[i];
  end

endmodule

// File: tb/tb_neuron_weight_bank.sv
// tb_neuron_weight_bank: self-checking bench for neuron_weight_bank with a
// small layer (2 neurons, 3 weights + bias each). A stream-level model keeps
// a linear word index into the layer and a per-neuron memory array; a
// negedge process compares every output against it each cycle, and directed
// sequences pin hand-computed literal values.
module tb_neuron_weight_bank;
  import nwb_pkg::*;

  localparam int N     = 2;
  localparam int D     = 3;
  localparam int W     = 16;
  localparam int AB    = 10;
  localparam int TOTAL = nwb_word_count(N, D);

  logic          clock = 1'b0;
  logic          resetn;
  logic          load_start = 1'b0;
  logic [W-1:0]  w_data = '0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic          rd_en = 1'b0;
  logic [AB-1:0] rd_addr = '0;
  logic [N*W-1:0] rd_data;
  logic          rd_valid;
  logic          rd_addr_err;
  logic [N-1:0]  neuron_loaded;
  logic          all_loaded;

  int compared   = 0;
  int mismatched = 0;

  neuron_weight_bank #(
    .N_NEURONS (N),
    .DEPTH     (D),
    .WIDTH     (W),
    .ADDR_BITS (AB)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .load_start    (load_start),
    .w_data        (w_data),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_addr_err   (rd_addr_err),
    .neuron_loaded (neuron_loaded),
    .all_loaded    (all_loaded)
  );

  always #5 clock = ~clock;

  // Model state: a load is a walk of m_idx through 0..TOTAL-1 in stream
  // order; word m_idx belongs to neuron m_idx/(D+1), slot m_idx%(D+1).
  logic         m_loading;
  logic         m_ready;
  int           m_idx;
  logic [W-1:0] m_mem [N][D+1];
  logic         m_rd_valid;
  logic         m_rd_err;
  logic [N*W-1:0] m_rd_data;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_loading  <= 1'b0;
      m_ready    <= 1'b0;
      m_idx      <= 0;
      m_rd_valid <= 1'b0;
      m_rd_err   <= 1'b0;
      m_rd_data  <= '0;
    end else begin
      m_rd_valid <= 1'b0;
      m_rd_err   <= 1'b0;
      if (m_ready && rd_en) begin
        m_rd_valid <= 1'b1;
        if (int'(rd_addr) > D) begin
          m_rd_err  <= 1'b1;
          m_rd_data <= '0;
        end else begin
          for (int i = 0; i < N; i++) begin
            m_rd_data[i*W +: W] <= m_mem[i][int'(rd_addr)];
          end
        end
      end
      if (load_start) begin
        m_loading <= 1'b1;
        m_ready   <= 1'b0;
        m_idx     <= 0;
      end else if (m_loading && w_valid) begin
        m_mem[m_idx / (D + 1)][m_idx % (D + 1)] <= w_data;
        m_idx <= m_idx + 1;
        if (m_idx + 1 == TOTAL) begin
          m_loading <= 1'b0;
          m_ready   <= 1'b1;
        end
      end
    end
  end

  // A neuron is complete once the stream has moved past its bias word.
  function automatic logic [N-1:0] modelFlags();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) begin
      f[i] = (m_idx >= (i + 1) * (D + 1));
    end
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    checkOutput("w_ready",       64'(w_ready),       64'(m_loading));
    checkOutput("neuron_loaded", 64'(neuron_loaded), 64'(modelFlags()));
    checkOutput("all_loaded",    64'(all_loaded),    64'(m_ready));
    checkOutput("rd_valid",      64'(rd_valid),      64'(m_rd_valid));
    checkOutput("rd_addr_err",   64'(rd_addr_err),   64'(m_rd_err));
    checkOutput("rd_data",       64'(rd_data),       64'(m_rd_data));
  end

  // Drive one cycle of inputs, then return just after the next rising edge.
  task automatic applyStimulus(input logic ls, input logic wv, input logic [W-1:0] wd,
                               input logic re, input logic [AB-1:0] ra);
    load_start = ls;
    w_valid    = wv;
    w_data     = wd;
    rd_en      = re;
    rd_addr    = ra;
    @(posedge clock);
    #1;
  endtask

  task automatic streamWords(input int first, input int count, input bit gaps);
    int guard;
    for (int j = 0; j < count; j++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      end
      guard = 0;
      while (!w_ready && guard < 20) begin
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
        guard++;
      end
      compared++;
      if (!w_ready) begin
        mismatched++;
        $display("[TB] FAIL w_ready_wait: got 0 after %0d cycles, expected 1", guard);
      end
      applyStimulus(1'b0, 1'b1, W'(first + j), 1'b0, '0);
    end
  endtask

  task automatic readCheck(input int addr, input logic [N*W-1:0] exp_data, input logic exp_err);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, AB'(addr));
    checkOutput("lit_rd_valid", 64'(rd_valid),    64'd1);
    checkOutput("lit_rd_data",  64'(rd_data),     64'(exp_data));
    checkOutput("lit_rd_err",   64'(rd_addr_err), 64'(exp_err));
  endtask

  initial begin
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (2) @(posedge clock);
    #3 resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("lit_reset_w_ready", 64'(w_ready),       64'd0);
    checkOutput("lit_reset_loaded",  64'(neuron_loaded), 64'd0);
    checkOutput("lit_reset_all",     64'(all_loaded),    64'd0);
    checkOutput("lit_reset_rd_data", 64'(rd_data),       64'd0);

    // Read while idle is not honoured.
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 10'd1);
    checkOutput("lit_idle_rd_valid", 64'(rd_valid), 64'd0);

    // Contiguous load of words 1..8.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    streamWords(1, 4, 1'b0);
    checkOutput("lit_loaded_w4", 64'(neuron_loaded), 64'b01);
    checkOutput("lit_all_w4",    64'(all_loaded),    64'd0);
    streamWords(5, 4, 1'b0);
    checkOutput("lit_loaded_w8", 64'(neuron_loaded), 64'b11);
    checkOutput("lit_all_w8",    64'(all_loaded),    64'd1);
    checkOutput("lit_ready_w8",  64'(w_ready),       64'd0);

    // Back-to-back broadcast reads, including out-of-range.
    readCheck(0, 32'h0005_0001, 1'b0);
    readCheck(1, 32'h0006_0002, 1'b0);
    readCheck(2, 32'h0007_0003, 1'b0);
    readCheck(3, 32'h0008_0004, 1'b0);
    readCheck(4, 32'h0000_0000, 1'b1);
    readCheck(1, 32'h0006_0002, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("lit_idle_valid", 64'(rd_valid), 64'd0);
    checkOutput("lit_hold_data",  64'(rd_data),  64'h0006_0002);

    // Reload with random gaps, then junk words while READY.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    streamWords(1, 8, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1, 16'hdead, 1'b0, '0);
    readCheck(2, 32'h0007_0003, 1'b0);
    readCheck(0, 32'h0005_0001, 1'b0);
    readCheck(3, 32'h0008_0004, 1'b0);

    // Restart mid-load; the word alongside load_start is dropped.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    streamWords(100, 5, 1'b0);
    checkOutput("lit_partial_loaded", 64'(neuron_loaded), 64'b01);
    applyStimulus(1'b1, 1'b1, 16'd99, 1'b0, '0);
    checkOutput("lit_restart_loaded", 64'(neuron_loaded), 64'b00);
    checkOutput("lit_restart_ready",  64'(w_ready),       64'd1);
    streamWords(11, 8, 1'b0);
    checkOutput("lit_reload_all", 64'(all_loaded), 64'd1);
    readCheck(0, 32'h000f_000b, 1'b0);
    readCheck(3, 32'h0012_000e, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);

    // Asynchronous reset in the middle of a load.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    streamWords(41, 3, 1'b0);
    #3 resetn = 1'b0;
    #1;
    checkOutput("lit_areset_w_ready", 64'(w_ready),       64'd0);
    checkOutput("lit_areset_loaded",  64'(neuron_loaded), 64'd0);
    checkOutput("lit_areset_rd_data", 64'(rd_data),       64'd0);
    checkOutput("lit_areset_valid",   64'(rd_valid),      64'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 10'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 10'd0);
    #2 resetn = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b1, 10'd2);
    checkOutput("lit_post_reset_valid", 64'(rd_valid), 64'd0);

    // Full load after reset brings reads back.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    streamWords(31, 8, 1'b1);
    readCheck(1, 32'h0024_0020, 1'b0);
    readCheck(3, 32'h0026_0022, 1'b0);
    readCheck(9, 32'h0000_0000, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
